// File: rtl/pipe_result_reader.sv
// Streams a contiguous block of the ALU result memory out on a valid/ready port,
// keeping a running mod-2^16 checksum of the words handed off.
module pipe_result_reader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;

  // One read can be outstanding; its address/last tag travel alongside it.
  logic                inflight_q;
  logic [ADDR_W-1:0]   inflight_addr_q;
  logic                inflight_last_q;

  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic                fifo_last_q [FIFO_DEPTH];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          occ_q, occ_d;

  logic                push;
  logic                pop;
  logic                issue;
  logic                last_issue;
  logic [1:0]          occ_after_pop;
  logic [1:0]          slots_used;

  assign push       = inflight_q;
  assign out_valid  = (occ_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_data   = fifo_data_q[rd_ptr_q];
  assign out_addr   = fifo_addr_q[rd_ptr_q];
  assign out_last   = fifo_last_q[rd_ptr_q];
  assign last_issue = (remaining_q == (ADDR_W + 1)'(1));

  // A slot freed by this cycle's pop is reusable now, which is what sustains
  // one word per cycle with only two entries of buffering.
  assign occ_after_pop = occ_q - 2'(pop);
  assign slots_used    = occ_after_pop + 2'(inflight_q);
  assign issue         = (state_q == StRun) && (remaining_q != '0) && (slots_used < 2'd2);

  assign mem_re   = issue;
  assign mem_addr = addr_q;
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign checksum = checksum_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    checksum_d  = pop ? (checksum_q + out_data) : checksum_q;
    occ_d       = occ_q + 2'(push) - 2'(pop);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          checksum_d = '0;
          if (count != '0) begin
            addr_d      = base_addr;
            remaining_d = count;
            state_d     = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W + 1)'(1);
          if (last_issue) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      checksum_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      inflight_last_q <= 1'b0;
      occ_q           <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      checksum_q      <= checksum_d;
      inflight_q      <= issue;
      inflight_addr_q <= addr_q;
      inflight_last_q <= last_issue;
      occ_q           <= occ_d;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rdata;
      fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

endmodule

// File: tb/tb_pipe_result_reader.sv
// Scoreboard bench for pipe_result_reader: directed blocks queue expected words,
// a negedge monitor pops and compares every handoff.
module tb_pipe_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic [15:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  pipe_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  logic [15:0] mem [256];
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  addr;
    logic        last;
  } word_t;

  word_t exp_q[$];
  word_t mon_e;
  word_t stall_head;
  logic  stall_prev = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int issued = 0;
  int handed = 0;
  int hand_seen = 0;
  int last_hand_cyc = 0;
  int gaps = 0;
  int stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      issued <= 0;
      handed <= 0;
    end else begin
      if (mem_re) issued <= issued + 1;
      if (out_valid && out_ready) handed <= handed + 1;
    end
  end

  // Monitor: compares handoffs against the queue, checks stall stability and credits.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold", {6'd0, out_valid, out_data, out_addr, out_last}, {6'd0, 1'b1, stall_head});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got data 0x%0h addr 0x%0h, expected none", out_data,
                   out_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, mon_e.data});
          chk("out_addr", {24'd0, out_addr}, {24'd0, mon_e.addr});
          chk("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
        end
        if (hand_seen > 0 && cyc != last_hand_cyc + 1) gaps++;
        hand_seen++;
        last_hand_cyc = cyc;
      end
      if (out_valid && !out_ready) stalls++;
      stall_prev = out_valid && !out_ready;
      stall_head = {out_data, out_addr, out_last};
      chk("fifo_bound", {31'd0, (issued - handed) <= 2}, 32'd1);
      if ((issued - handed) == 2 && !out_ready) chk("credit_block", {31'd0, mem_re}, 32'd0);
    end
  end

  // out_ready pattern 1,0,0,1,0,1 while enabled
  logic       toggle_mode = 1'b0;
  logic [5:0] rpat = 6'b101001;
  int         ridx = 0;
  always @(posedge clk) begin
    #1;
    if (toggle_mode) begin
      out_ready = rpat[ridx];
      ridx = (ridx + 1) % 6;
    end
  end

  task automatic start_block(input logic [7:0] b, input logic [8:0] c);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_done: no done pulse within %0d cycles", limit);
    end
  endtask

  task automatic push_block(input logic [7:0] b, input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = b + 8'(i);
      w.data = mem[w.addr];
      w.last = (i == n - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_times3();
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_out_addr"}, {24'd0, out_addr}, 32'd0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_checksum"}, {16'd0, checksum}, 32'd0);
  endtask

  task automatic finish_checks(input string tag, input logic [15:0] sum, input int words);
    chk({tag, "_checksum"}, {16'd0, checksum}, {16'd0, sum});
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_words"}, hand_seen, words);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bit seen_done;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    out_ready = 1'b1;
    fill_times3();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Block 1: base 0x10, count 4, mem[i]=i*3, latency and back-to-back handoffs
    hand_seen = 0; gaps = 0;
    push_block(8'h10, 4);
    start_block(8'h10, 9'd4);
    @(negedge clk);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_mem_re", {31'd0, mem_re}, 32'd1);
    chk("lat_mem_addr", {24'd0, mem_addr}, 32'h10);
    chk("lat_valid0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid2", {31'd0, out_valid}, 32'd1);
    wait_done(20);
    chk("b1_gaps", gaps, 32'd0);
    finish_checks("b1", 16'h00D2, 4);

    // Block 2: address wrap FE..01
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    hand_seen = 0; gaps = 0;
    push_block(8'hFE, 4);
    start_block(8'hFE, 9'd4);
    wait_done(20);
    chk("b2_gaps", gaps, 32'd0);
    finish_checks("b2", 16'h41FE, 4);

    // Block 3: same block under back-pressure
    hand_seen = 0; stalls = 0;
    push_block(8'hFE, 4);
    ridx = 0;
    toggle_mode = 1'b1;
    start_block(8'hFE, 9'd4);
    wait_done(60);
    chk("b3_stalls_seen", {31'd0, stalls != 0}, 32'd1);
    finish_checks("b3", 16'h41FE, 4);
    toggle_mode = 1'b0;
    out_ready = 1'b1;

    // Block 4: count=0, plus a start during DONE is ignored
    snap = issued;
    start_block(8'h33, 9'd0);
    @(negedge clk);
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_busy", {31'd0, busy}, 32'd0);
    chk("z_valid", {31'd0, out_valid}, 32'd0);
    chk("z_checksum", {16'd0, checksum}, 32'd0);
    start = 1'b1; base_addr = 8'h20; count = 9'd2;
    @(negedge clk);
    start = 1'b0;
    chk("z_done_gone", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("z_start_in_done_ignored", {31'd0, busy}, 32'd0);
    chk("z_no_reads", issued - snap, 32'd0);
    chk("z_no_words", {31'd0, out_valid}, 32'd0);

    // Block 5: second start during RUN is ignored
    fill_times3();
    hand_seen = 0;
    push_block(8'h10, 4);
    start_block(8'h10, 9'd4);
    @(negedge clk);
    start = 1'b1; base_addr = 8'h80; count = 9'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    finish_checks("b5", 16'h00D2, 4);

    // Block 6: count=256 of 16'hFFFF
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    hand_seen = 0; gaps = 0;
    push_block(8'h37, 256);
    start_block(8'h37, 9'd256);
    wait_done(400);
    chk("b6_gaps", gaps, 32'd0);
    finish_checks("b6", 16'hFF00, 256);

    // Block 7: reset after two handoffs of an 8-word block, then a clean restart
    fill_times3();
    hand_seen = 0;
    push_block(8'h40, 8);
    start_block(8'h40, 9'd8);
    snap = 0;
    for (int i = 0; i < 30 && hand_seen < 2; i++) begin
      @(negedge clk);
      #1;
    end
    chk("r_two_handoffs", hand_seen, 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, seen_done}, 32'd0);
    out_ready = 1'b1;
    hand_seen = 0;
    push_block(8'hC0, 3);
    start_block(8'hC0, 9'd3);
    wait_done(20);
    finish_checks("after_rst", 16'h06C9, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
